// File: rtl/rob_retire.sv
// rob_retire: in-order commit of up to EXT_COUNT ROB slots per cycle with store-commit handshake.
// Define RETIRE_PERF_CNT_EN to add the perf_retired/perf_killed counters.
module rob_retire #(
   parameter int EXT_COUNT    = 4,
   parameter int EXTCOUNTLOG2 = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [EXT_COUNT-1:0]            slot_valid,
   input  logic [EXT_COUNT-1:0]            slot_kill,
   input  logic [EXT_COUNT-1:0][4:0]       slot_dest_reg,
   input  logic [EXT_COUNT-1:0]            slot_dest_vld,
   input  logic [EXT_COUNT-1:0][31:0]      slot_result,
   input  logic [EXT_COUNT-1:0]            slot_is_store,
   output logic                            consume,
   output logic [EXTCOUNTLOG2-1:0]         consume_count,
   output logic [EXT_COUNT-1:0]            rf_wr_en,
   output logic [EXT_COUNT-1:0][4:0]       rf_wr_addr,
   output logic [EXT_COUNT-1:0][31:0]      rf_wr_data,
   output logic                            st_commit_req,
   input  logic                            st_commit_ack
`ifdef RETIRE_PERF_CNT_EN
   ,
   output logic [31:0]                     perf_retired,
   output logic [31:0]                     perf_killed
`endif
);
   typedef enum logic {IDLE, ST_WAIT} state_t;
   state_t                       state_q, state_d;
   logic                         req_q, req_d;
   logic [EXT_COUNT-1:0]         wr_en_q, wr_en_d;
   logic [EXT_COUNT-1:0][4:0]    wr_addr_q, wr_addr_d;
   logic [EXT_COUNT-1:0][31:0]   wr_data_q, wr_data_d;
   logic [EXTCOUNTLOG2:0]        run_len;
   logic [EXT_COUNT-1:0]         run_mask, ret_mask, wr_cand;
   logic                         stop, store_head, store_ret;
   // Contiguous run of completed slots, cut at the first invalid slot or live store.
   always_comb begin
      run_len  = '0;
      run_mask = '0;
      stop     = 1'b0;
      for (int i = 0; i < EXT_COUNT; i++) begin
         if (!slot_valid[i] || (slot_is_store[i] && !slot_kill[i])) stop = 1'b1;
         run_mask[i] = !stop;
         run_len     = stop ? run_len : run_len + 1'b1;
      end
      store_head = slot_valid[0] && slot_is_store[0] && !slot_kill[0];
   end
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      consume       = 1'b0;
      consume_count = '0;
      ret_mask      = '0;
      store_ret     = 1'b0;
      if (state_q == IDLE) begin
         if (run_len != '0) begin
            consume       = 1'b1;
            consume_count = EXTCOUNTLOG2'(run_len - 1'b1);
            ret_mask      = run_mask;
         end else if (store_head) begin
            state_d = ST_WAIT;
            req_d   = 1'b1;
         end
      end else if (st_commit_ack) begin
         consume   = 1'b1;
         store_ret = 1'b1;
         state_d   = IDLE;
         req_d     = 1'b0;
      end
   end
   // Older lanes lose to a younger lane writing the same register in the same group.
   always_comb begin
      wr_cand   = '0;
      wr_en_d   = '0;
      wr_addr_d = '0;
      wr_data_d = '0;
      for (int i = 0; i < EXT_COUNT; i++)
         wr_cand[i] = ret_mask[i] && !slot_kill[i] && !slot_is_store[i] &&
                      slot_dest_vld[i] && (slot_dest_reg[i] != 5'd0);
      for (int i = 0; i < EXT_COUNT; i++) begin
         wr_en_d[i] = wr_cand[i];
         for (int j = i + 1; j < EXT_COUNT; j++)
            if (wr_cand[j] && slot_dest_reg[j] == slot_dest_reg[i]) wr_en_d[i] = 1'b0;
         wr_addr_d[i] = wr_en_d[i] ? slot_dest_reg[i] : 5'd0;
         wr_data_d[i] = wr_en_d[i] ? slot_result[i] : 32'd0;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end
   assign st_commit_req = req_q;
   assign rf_wr_en      = wr_en_q;
   assign rf_wr_addr    = wr_addr_q;
   assign rf_wr_data    = wr_data_q;
`ifdef RETIRE_PERF_CNT_EN
   logic [31:0] retired_q, retired_d, killed_q, killed_d;
   always_comb begin
      retired_d = retired_q + 32'(store_ret);
      killed_d  = killed_q;
      for (int i = 0; i < EXT_COUNT; i++) begin
         retired_d = retired_d + 32'(ret_mask[i] && !slot_kill[i]);
         killed_d  = killed_d + 32'(ret_mask[i] && slot_kill[i]);
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retired_q <= '0;
         killed_q  <= '0;
      end else begin
         retired_q <= retired_d;
         killed_q  <= killed_d;
      end
   end
   assign perf_retired = retired_q;
   assign perf_killed  = killed_q;
`endif
endmodule
